// File: rtl/mem_data_banked.sv
// Banked word memory with a 2-cycle pipelined read port, write-first bypass,
// and a power-on/reset clear sweep that zeroes every bank before accepting
// requests.

// One bank: a single-write, single-read array with a registered read.
// A same-cycle write to the word being read is forwarded (write-first).
module mem_data_bank #(
    parameter int WIDTH    = 32,
    parameter int IDX_BITS = 8
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic                re_i,
    input  logic [IDX_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]    rdata_o
);
    logic [WIDTH-1:0] mem_q [2**IDX_BITS];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Forward the incoming write when it hits the word being read
    always_comb begin
        rdata_d = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) rdata_d = wdata_i;
    end

    // Array write and registered array read
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
endmodule

module mem_data_banked #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 9,
    parameter int BANK_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_int_wr_en,
    input  logic [ADDR_BITS-1:0] data_int_wr_addr,
    input  logic [WIDTH-1:0]     data_int_wr_data,
    input  logic                 data_int_rd_en,
    input  logic [ADDR_BITS-1:0] data_int_rd_addr,
    output logic [WIDTH-1:0]     data_int_rd_data,
    output logic                 data_int_rd_valid,
    output logic                 busy
);
    localparam int IDX_BITS = ADDR_BITS - BANK_BITS;
    localparam int BANKS    = 1 << BANK_BITS;
    // Bank-select width; kept at least 1 so a single-bank build still has a select
    localparam int BSW      = (BANK_BITS > 0) ? BANK_BITS : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state_q;
    logic [IDX_BITS-1:0]   sweep_q;
    logic                  busy_q;
    logic [1:0]            vld_pipe_q;   // [0]: array read done, [1]: output register
    logic [BSW-1:0]        rd_sel_q;
    logic [WIDTH-1:0]      rd_data_q;
    logic [WIDTH-1:0]      rd_mux_d;

    logic                  run;
    logic                  sweep_we;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [BSW-1:0]        wr_bank;
    logic [BSW-1:0]        rd_bank;
    logic [IDX_BITS-1:0]   wr_idx;
    logic [IDX_BITS-1:0]   rd_idx;
    logic [IDX_BITS-1:0]   bank_waddr;
    logic [WIDTH-1:0]      bank_wdata;
    logic [WIDTH-1:0]      bank_rdata [BANKS];

    // Requests only count in RUN and never in a reset cycle
    assign run      = (state_q == RUN) && !reset;
    assign sweep_we = (state_q == CLEAR) && !reset;
    assign wr_acc   = data_int_wr_en && run;
    assign rd_acc   = data_int_rd_en && run;

    // Low address bits pick the bank, the rest index inside it
    assign wr_idx = data_int_wr_addr[ADDR_BITS-1:BANK_BITS];
    assign rd_idx = data_int_rd_addr[ADDR_BITS-1:BANK_BITS];

    generate
        if (BANK_BITS > 0) begin : g_bsel
            assign wr_bank = data_int_wr_addr[BSW-1:0];
            assign rd_bank = data_int_rd_addr[BSW-1:0];
        end else begin : g_nobsel
            assign wr_bank = '0;
            assign rd_bank = '0;
        end
    endgenerate

    // The sweep writes the same index of every bank at once
    assign bank_waddr = sweep_we ? sweep_q : wr_idx;
    assign bank_wdata = sweep_we ? '0 : data_int_wr_data;

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            mem_data_bank #(
                .WIDTH   (WIDTH),
                .IDX_BITS(IDX_BITS)
            ) u_bank (
                .clk    (clk),
                .we_i   (sweep_we || (wr_acc && (wr_bank == BSW'(b)))),
                .waddr_i(bank_waddr),
                .wdata_i(bank_wdata),
                .re_i   (rd_acc && (rd_bank == BSW'(b))),
                .raddr_i(rd_idx),
                .rdata_o(bank_rdata[b])
            );
        end
    endgenerate

    // Pick the bank that served the read one cycle ago
    always_comb begin
        rd_mux_d = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (rd_sel_q == BSW'(b)) rd_mux_d = bank_rdata[b];
        end
    end

    // Controller: sweep every index to zero, then run until the next reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            sweep_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (sweep_q == {IDX_BITS{1'b1}}) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                        sweep_q <= '0;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= CLEAR;
                    sweep_q <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Read pipeline: valid tracks the bank read, data held when no read retires
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            rd_sel_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], rd_acc};
            rd_sel_q   <= rd_bank;
            if (vld_pipe_q[0]) rd_data_q <= rd_mux_d;
        end
    end

    assign data_int_rd_data  = rd_data_q;
    assign data_int_rd_valid = vld_pipe_q[1];
    assign busy              = busy_q;
endmodule

// File: doc/mem_data_banked.md
MEM_DATA_BANKED -- requirements
Module: mem_data_banked

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning the data word width in bits.
REQ-002 The module SHALL have parameter ADDR_BITS, default 9, meaning the total address width; depth = 2^ADDR_BITS words.
REQ-003 The module SHALL have parameter BANK_BITS, default 1, meaning bank-select width; BANKS = 2^BANK_BITS, 0 <= BANK_BITS < ADDR_BITS.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port data_int_wr_en, input, 1 bit: write request.
REQ-007 The module SHALL have port data_int_wr_addr, input, ADDR_BITS: write word address; low BANK_BITS select the bank.
REQ-008 The module SHALL have port data_int_wr_data, input, WIDTH: write data.
REQ-009 The module SHALL have port data_int_rd_en, input, 1 bit: read request.
REQ-010 The module SHALL have port data_int_rd_addr, input, ADDR_BITS: read word address.
REQ-011 The module SHALL have port data_int_rd_data, output, WIDTH: read data.
REQ-012 The module SHALL have port data_int_rd_valid, output, 1 bit: data_int_rd_data is valid this cycle.
REQ-013 The module SHALL have port busy, output, 1 bit: clear sweep in progress; requests ignored.

Function
REQ-014 Storage SHALL be BANKS independent arrays of 2^(ADDR_BITS-BANK_BITS) x WIDTH, with one read and one write per bank per cycle.
REQ-015 A write accepted in cycle N SHALL update the addressed word at the end of cycle N.
REQ-016 A read accepted in cycle N SHALL assert data_int_rd_valid and present data_int_rd_data in cycle N+2, giving a fixed 2-cycle latency: one cycle for the array read, one for the output register.
REQ-017 Reads SHALL be fully pipelined, so back-to-back reads in every cycle produce valid data in every cycle, in request order.
REQ-018 When a read and a write target the same address in the same cycle, the read SHALL return the new write data (write-first bypass).
REQ-019 When a read in cycle N targets an address written in cycle N-1, the read SHALL return the cycle N-1 write data.
REQ-020 Reads and writes to different banks or different addresses in the same cycle SHALL be independent and conflict-free.
REQ-021 When data_int_rd_en is low in cycle N, data_int_rd_valid SHALL be 0 in cycle N+2, and data_int_rd_data SHALL hold its previous value.
REQ-022 The controller SHALL be a two-state FSM, CLEAR and RUN.
REQ-023 In CLEAR, the controller SHALL write 0 to word index k of every bank simultaneously, k = 0..2^(ADDR_BITS-BANK_BITS)-1, one index per cycle.
REQ-024 After the last index is written, the FSM SHALL go to RUN in the next cycle.
REQ-025 busy SHALL be 1 exactly while in CLEAR.
REQ-026 While busy=1, data_int_wr_en and data_int_rd_en SHALL be ignored: no write, no rd_valid.
REQ-027 Reads SHALL NOT be accepted in the final CLEAR cycle.
REQ-028 RUN SHALL be held until reset.
REQ-029 Address arithmetic SHALL be unsigned with no wrap-around beyond the defined depth; every ADDR_BITS value is valid.

Reset
REQ-030 While reset=1, the FSM SHALL enter CLEAR with the sweep index at 0.
REQ-031 While reset=1, busy SHALL be 1.
REQ-032 While reset=1, data_int_rd_valid SHALL be 0, data_int_rd_data SHALL be 0, and all in-flight reads SHALL be discarded.
REQ-033 Reset asserted mid-sweep or mid-operation SHALL restart the full clear sweep from index 0 in the first cycle after reset deasserts.
REQ-034 Array contents SHALL be 0 after any completed sweep.

Verification
REQ-035 The bench SHALL cover clear sweep: with defaults, deassert reset -> busy=1 for 256 cycles then 0; a read of every address returns 0 with rd_valid 2 cycles after each request.
REQ-036 The bench SHALL cover the basic write/read case: write 0xDEADBEEF to 0x005, then read 0x005 two cycles later -> rd_data=0xDEADBEEF with rd_valid exactly 2 cycles after the read.
REQ-037 The bench SHALL cover bypass: same-cycle write 0x12345678 and read of 0x0A0 -> 0x12345678; a read in the cycle after a write of 0xCAFE0001 to 0x0A1 -> 0xCAFE0001.
REQ-038 The bench SHALL cover streaming: reads of 0x000..0x00F in 16 consecutive cycles after writing data=addr -> 16 consecutive rd_valid cycles returning 0..15 in order.
REQ-039 The bench SHALL cover a busy-window request: rd_en and wr_en of 0x1FF during the sweep -> no rd_valid, and a post-sweep read of 0x1FF returns 0.
REQ-040 The bench SHALL cover reset mid-stream: reset asserted with 2 reads in flight -> no rd_valid for those reads, and busy=1 for a full 256-cycle sweep after release.
